pwm_multi: RTL and testbench
============================

// Module: pwm_multi
// PURPOSE
// - N-channel PWM generator; each channel has independent high/low durations in clk cycles.
// - Successor to the single-channel PWM:
//   - parametrised counter width and channel count
//   - shadow/active double buffering, so updates are glitch-free at period boundaries
//   - per-channel enable, global resync, output inversion, end-of-period pulse
// - Sits between the control/register bus and the motor/LED drive pins.
// PARAMETERS
// - CHANNELS  4           number of independent PWM channels (1..16)
// - WIDTH     16          bit width of high/low durations and the per-channel counter
// - INVERT    {CHANNELS{1'b0}}  per-channel output polarity mask; 1 = drive ~pwm on that bit
// - ADDR_W    $clog2(CHANNELS) (min 1)  width of wr_ch
// PORTS
// - clk          in   1              system clock, all logic on posedge
// - rst          in   1              synchronous, active-high reset
// - wr_en        in   1              write strobe, one-cycle, for the shadow register write
// - wr_ch        in   ADDR_W         target channel; values >= CHANNELS are ignored
// - wr_sel       in   1              0 = high-time shadow, 1 = low-time shadow
// - wr_data      in   WIDTH          duration in cycles
// - enable       in   CHANNELS       per-channel run enable (level)
// - sync         in   1              one-cycle pulse: restart every enabled channel at period start
// - pwm          out  CHANNELS       registered PWM outputs, after INVERT is applied
// - period_done  out  CHANNELS       one-cycle pulse per channel, first cycle of each new period
// BEHAVIOUR
// - Reset: shadow/active high and low = 0; cnt = 0; state = IDLE; pwm = INVERT; period_done = 0.
// - Channel FSM: IDLE, HIGH, LOW. Raw output is 1 only in HIGH; pwm = raw ^ INVERT.
// - Outputs are registered: an event evaluated in cycle t is visible on pwm in cycle t+1.
// - Reload: active_high/active_low <= shadow, using the shadow value before any same-cycle write.
// - Period start, entered with cnt = 0:
//   - performs a reload
//   - next state = HIGH if new high != 0, else LOW if new low != 0, else LOW as a 1-cycle degenerate period
// - IDLE: when enable[i] is 1, perform period start.
// - HIGH: cnt++. When cnt == active_high-1, cnt <= 0 and go to LOW if active_low != 0, else period start.
// - LOW: cnt++. When cnt == active_low-1 (or in a degenerate period), period start.
// - period_done[i] = 1 in the first cycle of every period except the one entered from IDLE.
// - high = 0 with low != 0 gives constant raw 0. low = 0 with high != 0 gives constant raw 1.
// - Both 0 gives raw 0, with period_done asserted every cycle.
// - Period = high + low cycles. Max duration 2^WIDTH-1; counter never wraps, since the compare terminates it.
// - enable[i] = 0: the channel goes to IDLE next cycle, cnt = 0, raw = 0; active values are retained.
// - sync with enable[i] = 1: the channel performs period start regardless of state; no period_done.
//   - sync has priority over a phase end in the same cycle.
// - Writes:
//   - shadow update only; never disturbs the running period
//   - writes are accepted in any state, including while the channel is disabled
//   - last write before a reload wins
// - rst mid-period: everything returns to reset values on the next edge; enable is re-sampled afterwards.
// STRUCTURE
// - pwm_pkg:
//   - state enum typedef pwm_state_e (IDLE, HIGH, LOW)
//   - constants WR_SEL_HIGH = 1'b0, WR_SEL_LOW = 1'b1
// - Sub-module pwm_channel (parameter WIDTH):
//   - one FSM + counter + shadow/active registers
//   - ports: clk, rst, wr_high, wr_low, wr_data, enable, sync, raw, period_done
// - pwm_multi: address decode of wr_en/wr_ch/wr_sel, generate loop over CHANNELS, INVERT XOR.
// TESTING
// - CH0 high=3, low=2, enable[0]=1 -> pwm[0] repeats 1,1,1,0,0 from the cycle after enable;
//   period_done[0] pulses every 5 cycles.
// - Write high=1 mid-period (CH0 3/2) -> current period finishes 3/2; next period is 1/2;
//   no truncated or extra pulse.
// - Degenerate cases on CH1: high=0, low=4 -> pwm[1] constant 0; high=5, low=0 -> constant 1;
//   both 0 -> 0 with period_done[1] every cycle.
// - CH0 3/2 and CH2 2/2 running out of phase, then sync pulse -> both show their HIGH phase
//   starting the same cycle; no period_done that cycle.
// - Deassert enable[0] in HIGH -> pwm[0] = 0 next cycle; re-enable restarts with a full HIGH phase.
//   INVERT[3]=1 -> idle pwm[3] = 1.
// - rst asserted mid-period -> pwm = INVERT, period_done = 0;
//   wr_ch = CHANNELS (out of range) -> no channel changes.

Source files
------------

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared channel state encoding and write-select constants for pwm_multi
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwm_state_e;

  localparam logic WR_SEL_HIGH = 1'b0;
  localparam logic WR_SEL_LOW  = 1'b1;

endpackage

// File: rtl/pwm_if.sv
// rtl/pwm_if.sv - shadow-register write bus from the register block into pwm_multi
interface pwm_if #(
  parameter int ADDR_W = 2,
  parameter int WIDTH  = 16
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_ch;
  logic              wr_sel;
  logic [WIDTH-1:0]  wr_data;

  modport master (
    output wr_en,
    output wr_ch,
    output wr_sel,
    output wr_data
  );

  modport slave (
    input wr_en,
    input wr_ch,
    input wr_sel,
    input wr_data
  );

endinterface

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM channel: shadow/active durations, phase counter and IDLE/HIGH/LOW FSM
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_high,
  input  logic             wr_low,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             enable,
  input  logic             sync,
  output logic             raw,
  output logic             period_done
);

  pwm_state_e       state_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] shadow_high_q;
  logic [WIDTH-1:0] shadow_low_q;
  logic [WIDTH-1:0] act_high_q;
  logic [WIDTH-1:0] act_low_q;
  logic             raw_q;
  logic             pd_q;

  logic       high_end;
  logic       low_end;
  logic       wrap;
  logic       restart;
  pwm_state_e start_state_d;

  // A LOW phase with zero active low time is the one-cycle degenerate period.
  assign high_end      = (state_q == HIGH) && (cnt_q == act_high_q - WIDTH'(1));
  assign low_end       = (state_q == LOW) &&
                         ((act_low_q == '0) || (cnt_q == act_low_q - WIDTH'(1)));
  assign wrap          = low_end || (high_end && (act_low_q == '0));
  assign restart       = sync || (state_q == IDLE) || wrap;
  assign start_state_d = (shadow_high_q != '0) ? HIGH : LOW;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      shadow_high_q <= '0;
      shadow_low_q  <= '0;
      act_high_q    <= '0;
      act_low_q     <= '0;
      raw_q         <= 1'b0;
      pd_q          <= 1'b0;
    end else begin
      if (wr_high) shadow_high_q <= wr_data;
      if (wr_low)  shadow_low_q  <= wr_data;
      pd_q <= 1'b0;
      if (!enable) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        raw_q   <= 1'b0;
      end else if (restart) begin
        // Reload sees the shadow as it was before any write landing this cycle.
        act_high_q <= shadow_high_q;
        act_low_q  <= shadow_low_q;
        cnt_q      <= '0;
        state_q    <= start_state_d;
        raw_q      <= (start_state_d == HIGH);
        pd_q       <= wrap && !sync;
      end else if (high_end) begin
        state_q <= LOW;
        cnt_q   <= '0;
        raw_q   <= 1'b0;
      end else if (state_q == HIGH || state_q == LOW) begin
        cnt_q <= cnt_q + WIDTH'(1);
      end else begin
        state_q <= IDLE;
        cnt_q   <= '0;
        raw_q   <= 1'b0;
      end
    end
  end

  assign raw         = raw_q;
  assign period_done = pd_q;

endmodule

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - N-channel PWM generator: write decode, channel array and output polarity
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int                  CHANNELS = 4,
  parameter int                  WIDTH    = 16,
  parameter logic [CHANNELS-1:0] INVERT   = '0,
  parameter int                  ADDR_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  pwm_if.slave                wr,
  input  logic [CHANNELS-1:0] enable,
  input  logic                sync,
  output logic [CHANNELS-1:0] pwm,
  output logic [CHANNELS-1:0] period_done
);

  logic [CHANNELS-1:0] raw;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic hit;
    // Channel numbers at or above CHANNELS match no instance and are dropped.
    assign hit = wr.wr_en && (32'(wr.wr_ch) == i);

    pwm_channel #(
      .WIDTH(WIDTH)
    ) u_channel (
      .clk        (clk),
      .rst        (rst),
      .wr_high    (hit && (wr.wr_sel == WR_SEL_HIGH)),
      .wr_low     (hit && (wr.wr_sel == WR_SEL_LOW)),
      .wr_data    (wr.wr_data),
      .enable     (enable[i]),
      .sync       (sync),
      .raw        (raw[i]),
      .period_done(period_done[i])
    );
  end

  assign pwm = raw ^ INVERT;

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - scoreboard bench for pwm_multi with hand-computed per-cycle expectations
module tb_pwm_multi;

  localparam int         CH  = 4;
  localparam int         W   = 16;
  localparam int         AW  = 3;
  localparam logic [3:0] INV = 4'b1000;
  localparam logic [3:0] ALL = 4'b1111;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] enable;
  logic       sync;
  logic [3:0] pwm;
  logic [3:0] period_done;

  pwm_if #(.ADDR_W(AW), .WIDTH(W)) wr_bus ();

  pwm_multi #(
    .CHANNELS(CH),
    .WIDTH   (W),
    .INVERT  (INV),
    .ADDR_W  (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr_bus),
    .enable     (enable),
    .sync       (sync),
    .pwm        (pwm),
    .period_done(period_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mask;
    logic [3:0] ep;
    logic [3:0] ed;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.mask != 4'b0000) begin
          checks++;
          if ((pwm & e.mask) == (e.ep & e.mask)) passed++;
          else $display("FAIL %s pwm got %b exp %b (mask %b)", e.tag, pwm, e.ep, e.mask);
          checks++;
          if ((period_done & e.mask) == (e.ed & e.mask)) passed++;
          else $display("FAIL %s period_done got %b exp %b (mask %b)", e.tag, period_done, e.ed, e.mask);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: stimulus did not complete");
    $fatal(1, "timeout");
  end

  task automatic step(input logic [3:0] m, input logic [3:0] ep, input logic [3:0] ed,
                      input string tag);
    exp_t e;
    e.mask = m;
    e.ep   = ep;
    e.ed   = ed;
    e.tag  = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input logic sel, input int data, input logic [3:0] m,
                    input logic [3:0] ep, input logic [3:0] ed, input string tag);
    wr_bus.wr_en   = 1'b1;
    wr_bus.wr_ch   = AW'(ch);
    wr_bus.wr_sel  = sel;
    wr_bus.wr_data = W'(data);
    step(m, ep, ed, tag);
    wr_bus.wr_en   = 1'b0;
  endtask

  initial begin
    logic [3:0] p;
    logic [3:0] d;
    rst            = 1'b1;
    enable         = 4'b0000;
    sync           = 1'b0;
    wr_bus.wr_en   = 1'b0;
    wr_bus.wr_ch   = '0;
    wr_bus.wr_sel  = 1'b0;
    wr_bus.wr_data = '0;

    step(ALL, INV, 4'b0000, "reset0");
    step(ALL, INV, 4'b0000, "reset1");
    rst = 1'b0;

    // CH0 high=3 low=2
    wr(0, 1'b0, 3, ALL, INV, 4'b0000, "idle_wr_high");
    wr(0, 1'b1, 2, ALL, INV, 4'b0000, "idle_wr_low");
    enable[0] = 1'b1;
    for (int k = 0; k < 15; k++) begin
      p = INV; d = 4'b0000;
      p[0] = (k % 5) < 3;
      d[0] = (k % 5 == 0) && (k > 0);
      step(ALL, p, d, "ch0_3_2");
    end

    // high=1 written during HIGH: current period stays 3/2, next is 1/2
    for (int j = 0; j < 5; j++) begin
      p = INV; d = 4'b0000;
      p[0] = j < 3;
      d[0] = (j == 0);
      if (j == 1) wr(0, 1'b0, 1, ALL, p, d, "midwr_old");
      else        step(ALL, p, d, "midwr_old");
    end
    for (int m = 0; m < 9; m++) begin
      p = INV; d = 4'b0000;
      p[0] = (m % 3) == 0;
      d[0] = (m % 3) == 0;
      step(ALL, p, d, "midwr_new");
    end

    // CH1 degenerate: 0/4, 5/0, 0/0
    wr(1, 1'b1, 4, 4'b0010, 4'b0000, 4'b0000, "ch1_wr");
    enable[1] = 1'b1;
    for (int n = 0; n < 9; n++) begin
      d = 4'b0000;
      d[1] = (n % 4 == 0) && (n > 0);
      step(4'b0010, 4'b0000, d, "ch1_h0_l4");
    end
    enable[1] = 1'b0;
    step(4'b0010, 4'b0000, 4'b0000, "ch1_dis_a");
    wr(1, 1'b0, 5, 4'b0010, 4'b0000, 4'b0000, "ch1_wr_h5");
    wr(1, 1'b1, 0, 4'b0010, 4'b0000, 4'b0000, "ch1_wr_l0");
    enable[1] = 1'b1;
    for (int n = 0; n < 11; n++) begin
      d = 4'b0000;
      d[1] = (n % 5 == 0) && (n > 0);
      step(4'b0010, 4'b0010, d, "ch1_h5_l0");
    end
    enable[1] = 1'b0;
    step(4'b0010, 4'b0000, 4'b0000, "ch1_dis_b");
    wr(1, 1'b0, 0, 4'b0010, 4'b0000, 4'b0000, "ch1_wr_h0");
    enable[1] = 1'b1;
    for (int n = 0; n < 6; n++) begin
      d = 4'b0000;
      d[1] = (n > 0);
      step(4'b0010, 4'b0000, d, "ch1_h0_l0");
    end
    enable[1] = 1'b0;
    step(4'b0010, 4'b0000, 4'b0000, "ch1_dis_c");

    // CH0 3/2 and CH2 2/2 out of phase, then sync on CH0's wrap cycle
    enable[0] = 1'b0;
    step(4'b0101, 4'b0000, 4'b0000, "sync_dis");
    wr(0, 1'b0, 3, 4'b0101, 4'b0000, 4'b0000, "sync_wr0");
    wr(2, 1'b0, 2, 4'b0101, 4'b0000, 4'b0000, "sync_wr2h");
    wr(2, 1'b1, 2, 4'b0101, 4'b0000, 4'b0000, "sync_wr2l");
    enable[0] = 1'b1;
    step(4'b0101, 4'b0001, 4'b0000, "pre_sync0");
    step(4'b0101, 4'b0001, 4'b0000, "pre_sync1");
    enable[2] = 1'b1;
    step(4'b0101, 4'b0101, 4'b0000, "pre_sync2");
    step(4'b0101, 4'b0100, 4'b0000, "pre_sync3");
    step(4'b0101, 4'b0000, 4'b0000, "pre_sync4");
    for (int n = 0; n < 6; n++) begin
      sync = (n == 0);
      p = 4'b0000; d = 4'b0000;
      p[0] = (n % 5) < 3;
      d[0] = (n % 5 == 0) && (n > 0);
      p[2] = (n % 4) < 2;
      d[2] = (n % 4 == 0) && (n > 0);
      step(4'b0101, p, d, "sync");
    end
    sync = 1'b0;

    // disable CH0 during HIGH, then re-enable for a full period
    enable[0] = 1'b0;
    step(4'b0001, 4'b0000, 4'b0000, "dis_in_high");
    step(4'b0001, 4'b0000, 4'b0000, "dis_idle");
    enable[0] = 1'b1;
    for (int n = 0; n < 6; n++) begin
      p = 4'b0000; d = 4'b0000;
      p[0] = (n % 5) < 3;
      d[0] = (n == 5);
      step(4'b0001, p, d, "reenable");
    end

    // reset mid-period clears the shadows, so re-enabled channels run degenerate
    rst = 1'b1;
    step(ALL, INV, 4'b0000, "rst_mid");
    rst = 1'b0;
    step(ALL, INV, 4'b0000, "post_rst0");
    step(ALL, INV, 4'b0101, "post_rst1");

    // out-of-range channel writes are dropped
    enable = 4'b0000;
    step(ALL, INV, 4'b0000, "dis_all");
    wr(4, 1'b0, 7, ALL, INV, 4'b0000, "oor_wr4");
    wr(5, 1'b1, 7, ALL, INV, 4'b0000, "oor_wr5");
    wr(7, 1'b0, 9, ALL, INV, 4'b0000, "oor_wr7");
    enable = 4'b0111;
    step(ALL, INV, 4'b0000, "oor_run0");
    step(ALL, INV, 4'b0111, "oor_run1");

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain left %0d exp 0", sb.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
